mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single-port 256x16 RAM and the memory-mapped I/O (LEDR[7:0], SW[7:0]) between two
//  requesters: port A (CPU) and port B (debug/loader). Sits between them and the RAM, replacing
//  the ad-hoc msel/tristate decode. Two-way round-robin arbitration. One transaction per grant.
//  Handshake: command held until ack. Bit 8 of the address selects I/O; bits [7:0] address RAM.
// PARAMETERS
//  LED_ADDR   9'h100  I/O address of the write-only LED register
//  SW_ADDR    9'h140  I/O address of the read-only switch port
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   synchronous, active-low reset (asserted when 0)
//  a_cmd      in   2   port A command: MNONE 2'b00, MWRITE 2'b01, MREAD 2'b10; 2'b11 = MNONE
//  a_addr     in   9   port A address
//  a_wdata    in   16  port A write data
//  a_rdata    out  16  port A read data, valid in a_ack cycle, held until next A read completes
//  a_ack      out  1   one-cycle completion pulse for port A
//  b_cmd/b_addr/b_wdata/b_rdata/b_ack   same as port A, for port B
//  ram_addr   out  8   RAM read/write address
//  ram_write  out  1   RAM write enable
//  ram_din    out  16  RAM write data
//  ram_dout   in   16  RAM registered read data, valid 1 cycle after ram_addr is sampled
//  sw         in   8   slide switches
//  led        out  8   LED register
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): state=IDLE, a_ack=b_ack=0, ram_write=0, ram_addr=0,
//   ram_din=0, a_rdata=b_rdata=0, led=0, last_grant=B (A wins the first tie). Reset overrides
//   any transaction in flight: no ack for it, no RAM/LED write after the reset edge.
//  FSM: IDLE -> ACCESS -> [RD_WAIT] -> DONE -> IDLE.
//   IDLE: if either cmd is MREAD/MWRITE, pick the winner (only requester; on a tie, the port not
//    equal to last_grant). Latch owner, cmd, addr, wdata. Go to ACCESS. Otherwise stay.
//   ACCESS: ram_addr=latched addr[7:0]. ram_din=latched wdata.
//    RAM write (addr[8]=0, MWRITE): ram_write=1 this cycle only -> DONE.
//    RAM read  (addr[8]=0, MREAD): -> RD_WAIT.
//    I/O write: if addr==LED_ADDR, led<=wdata[7:0] at end of cycle. Other I/O addresses are
//     ignored. -> DONE.
//    I/O read: owner rdata<={{8{sw[7]}},sw} if addr==SW_ADDR, else 16'h0000. -> DONE.
//   RD_WAIT: owner rdata<=ram_dout at end of cycle -> DONE.
//   DONE: owner ack=1 for exactly this cycle. last_grant<=owner. -> IDLE.
//  Latency from the IDLE cycle that samples the command to the ack cycle:
//   RAM read 3 cycles, RAM write / I/O access 2 cycles. Minimum turnaround: 4 cycles per read.
//  Requester rules:
//   - Hold cmd/addr/wdata until ack. Drive the next command (or MNONE) in the cycle after ack;
//     back-to-back requests are legal.
//   - The arbiter uses only the values latched in IDLE. Changes mid-transaction do not affect
//     the transaction, and ack still pulses.
//  The loser's request stays pending and wins the next IDLE cycle. Under continuous requests
//   from both ports, grants strictly alternate A,B,A,B.
//  ram_write is never asserted outside ACCESS. a_ack and b_ack are never high together.
//  Non-owner rdata is unchanged by any transaction.
// STRUCTURE
//  Shared package mem_pkg: MNONE/MWRITE/MREAD, LED_ADDR/SW_ADDR defaults, FSM state encoding
//   (IDLE, ACCESS, RD_WAIT, DONE), port-id constants PORT_A/PORT_B.
//  Sub-module rr_arb2: inputs req_a, req_b, last_grant; output grant (combinational).
//  Everything else is inline in mem_bus_arbiter.
// TESTING
//  1. Reset, then a_cmd=MWRITE addr 9'h005 wdata 16'hBEEF -> ram_write=1 with ram_addr=8'h05,
//     ram_din=16'hBEEF one cycle; a_ack 2 cycles after the sampling cycle.
//  2. a_cmd=MREAD addr 9'h005, RAM model returns 16'hBEEF -> a_ack 3 cycles later with
//     a_rdata=16'hBEEF; b_rdata still 0.
//  3. Both ports MREAD in the same cycle after reset -> A served first, then B. Hold both
//     requests for 6 grants -> ack order A,B,A,B,A,B.
//  4. b_cmd=MWRITE 9'h100 wdata 16'h00A5 -> led=8'hA5, no ram_write. MWRITE 9'h180 -> led
//     unchanged, b_ack still pulses.
//  5. sw=8'h80, a_cmd=MREAD 9'h140 -> a_rdata=16'hFF80. MREAD 9'h1C0 -> a_rdata=16'h0000.
//  6. Drive reset=0 in RD_WAIT of an A read -> no a_ack, state IDLE, led=0. The next request
//     is served normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory bus arbiter: bus commands, default I/O map,
// FSM state encoding and requester identifiers.
package mem_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MWRITE = 2'b01,
    MREAD  = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RD_WAIT = 2'b10,
    DONE    = 2'b11
  } arb_state_e;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // 2'b11 is treated as MNONE, so only the two real commands count as requests.
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == MWRITE) || (cmd == MREAD);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arb2
  import mem_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant
);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant = PORT_A;
    if (req_a && req_b) begin
      grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the 256x16 single-port RAM and the LED/switch I/O between a CPU port (A)
// and a debug/loader port (B); one transaction per grant, round-robin between ports.
module mem_bus_arbiter
  import mem_pkg::*;
#(
  parameter logic [8:0] LED_ADDR = LED_ADDR_DEF,
  parameter logic [8:0] SW_ADDR  = SW_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  a_cmd,
  input  logic [8:0]  a_addr,
  input  logic [15:0] a_wdata,
  output logic [15:0] a_rdata,
  output logic        a_ack,
  input  logic [1:0]  b_cmd,
  input  logic [8:0]  b_addr,
  input  logic [15:0] b_wdata,
  output logic [15:0] b_rdata,
  output logic        b_ack,
  output logic [7:0]  ram_addr,
  output logic        ram_write,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        busy
);

  arb_state_e  state, state_nxt;
  logic        owner, last_grant, grant;
  logic        lat_write;
  logic [8:0]  lat_addr;
  logic [15:0] lat_wdata;
  logic        req_a, req_b;
  logic        rd_load;
  logic [15:0] rd_value;

  assign req_a = is_req(a_cmd);
  assign req_b = is_req(b_cmd);

  rr_arb2 u_arb (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // The RAM bus is driven straight from the latched command, so requester
  // changes after the IDLE cycle never reach the memory.
  assign ram_addr = lat_addr[7:0];
  assign ram_din  = lat_wdata;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    ram_write = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    rd_load   = 1'b0;
    rd_value  = ram_dout;
    case (state)
      IDLE: begin
        if (req_a || req_b) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!lat_addr[8]) begin
          ram_write = lat_write;
          state_nxt = lat_write ? DONE : RD_WAIT;
        end else begin
          rd_load   = !lat_write;
          rd_value  = (lat_addr == SW_ADDR) ? {{8{sw[7]}}, sw} : 16'h0000;
          state_nxt = DONE;
        end
      end
      RD_WAIT: begin
        rd_load   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        a_ack     = (owner == PORT_A);
        b_ack     = (owner == PORT_B);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= PORT_A;
      last_grant <= PORT_B;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      led        <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (req_a || req_b)) begin
        owner     <= grant;
        lat_write <= (grant == PORT_A) ? (a_cmd == MWRITE) : (b_cmd == MWRITE);
        lat_addr  <= (grant == PORT_A) ? a_addr : b_addr;
        lat_wdata <= (grant == PORT_A) ? a_wdata : b_wdata;
      end
      if (state == ACCESS && lat_write && lat_addr[8] && lat_addr == LED_ADDR) begin
        led <= lat_wdata[7:0];
      end
      if (rd_load) begin
        if (owner == PORT_A) a_rdata <= rd_value;
        else                 b_rdata <= rd_value;
      end
      if (state == DONE) last_grant <= owner;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: requester tasks push expected responses,
// a monitor pops and compares on every ack.
module tb_mem_bus_arbiter;
  import mem_pkg::*;

  localparam logic [8:0] LED_A = 9'h100;
  localparam logic [8:0] SW_A  = 9'h140;

  typedef struct {
    logic        is_read;
    logic [15:0] rdata;
    logic        chk_led;
    logic [7:0]  led;
    int          lat;
    int          issue_cyc;
  } exp_t;

  logic        clk, reset;
  logic [1:0]  a_cmd, b_cmd;
  logic [8:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic        a_ack, b_ack;
  logic [7:0]  ram_addr, sw, led;
  logic        ram_write, busy;
  logic [15:0] ram_din, ram_dout;

  logic [15:0] mem    [256];
  logic [15:0] shadow [256];
  logic [7:0]  exp_led;
  logic [15:0] exp_hold [2];
  exp_t        q_a[$], q_b[$];
  int          ack_log[$];
  int          n_checks, n_fail, cyc, wr_cnt, wr0;
  logic [7:0]  last_wr_addr;
  logic [15:0] last_wr_data;
  bit          random_phase;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .a_cmd(a_cmd), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
    .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout),
    .sw(sw), .led(led), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM seen by the arbiter.
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
    cyc      <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour: what a transaction returns, computed from the address map.
  task automatic model(input int p, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] wdata, output exp_t e);
    e.is_read   = (cmd == MREAD);
    e.rdata     = 16'h0000;
    e.lat       = 0;
    e.issue_cyc = 0;
    if (cmd == MWRITE) begin
      if (!addr[8])           shadow[addr[7:0]] = wdata;
      else if (addr == LED_A) exp_led = wdata[7:0];
    end else if (cmd == MREAD) begin
      if (!addr[8])          e.rdata = shadow[addr[7:0]];
      else if (addr == SW_A) e.rdata = {{8{sw[7]}}, sw};
    end
    e.chk_led = (p == 1) || !random_phase;
    e.led     = exp_led;
  endtask

  task automatic drive(input int p, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] wdata);
    if (p == 0) begin a_cmd = cmd; a_addr = addr; a_wdata = wdata; end
    else        begin b_cmd = cmd; b_addr = addr; b_wdata = wdata; end
  endtask

  // Issue one transaction at a negedge, hold it until ack, release in the following cycle.
  task automatic issue(input int p, input logic [1:0] cmd, input logic [8:0] addr,
                       input logic [15:0] wdata, input int lat, input bit scramble);
    exp_t e;
    bit   got;
    model(p, cmd, addr, wdata, e);
    e.lat       = lat;
    e.issue_cyc = cyc;
    if (p == 0) q_a.push_back(e);
    else        q_b.push_back(e);
    drive(p, cmd, addr, wdata);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (scramble && i == 0) drive(p, cmd, ~addr, ~wdata);
      if ((p == 0) ? a_ack : b_ack) begin
        got = 1;
        break;
      end
    end
    check($sformatf("ack_timeout_p%0d", p), 32'(got), 1);
    @(negedge clk);
    drive(p, MNONE, 9'h000, 16'h0000);
  endtask

  task automatic on_ack(input int p);
    exp_t e;
    if (p == 0) begin
      check("ack_expected_a", 32'(q_a.size() > 0), 1);
      if (q_a.size() == 0) return;
      e = q_a.pop_front();
    end else begin
      check("ack_expected_b", 32'(q_b.size() > 0), 1);
      if (q_b.size() == 0) return;
      e = q_b.pop_front();
    end
    if (e.is_read) exp_hold[p] = e.rdata;
    check($sformatf("rdata_p%0d", p), (p == 0) ? a_rdata : b_rdata, exp_hold[p]);
    check($sformatf("other_rdata_p%0d", 1 - p), (p == 0) ? b_rdata : a_rdata, exp_hold[1 - p]);
    if (e.lat > 0) check($sformatf("latency_p%0d", p), cyc - e.issue_cyc, e.lat);
    if (e.chk_led) check("led", led, e.led);
    ack_log.push_back(p);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (ram_write) begin
        wr_cnt++;
        last_wr_addr = ram_addr;
        last_wr_data = ram_din;
        check("ram_write_while_idle", busy, 1);
      end
      if (a_ack || b_ack) check("ack_exclusive", 32'(a_ack & b_ack), 0);
      if (a_ack) on_ack(0);
      if (b_ack) on_ack(1);
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    drive(0, MNONE, 9'h000, 16'h0000);
    drive(1, MNONE, 9'h000, 16'h0000);
    repeat (3) @(negedge clk);
    exp_hold[0] = 16'h0000;
    exp_hold[1] = 16'h0000;
    exp_led     = 8'h00;
    reset       = 1'b1;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [1:0]  cmd;
    logic [8:0]  addr;
    int          r;
    for (int k = 0; k < n; k++) begin
      drive(p, 2'b11, 9'h000, 16'h0000);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      cmd = ($urandom_range(0, 1) == 0) ? MREAD : MWRITE;
      r   = $urandom_range(0, 9);
      if (r < 6)       addr = {1'b0, p[0], 7'($urandom)};
      else if (r < 8)  addr = (p == 1 && cmd == MWRITE) ? LED_A : SW_A;
      else if (r == 8) addr = 9'h180;
      else             addr = 9'h1FF;
      issue(p, cmd, addr, 16'($urandom), 0, 0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    n_checks = 0; n_fail = 0; cyc = 0; wr_cnt = 0;
    random_phase = 0;
    exp_led = 8'h00;
    exp_hold[0] = 16'h0000;
    exp_hold[1] = 16'h0000;
    sw = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 16'h0000;
      shadow[i] = 16'h0000;
    end
    reset = 1'b0;
    drive(0, MNONE, 9'h000, 16'h0000);
    drive(1, MNONE, 9'h000, 16'h0000);
    repeat (3) @(negedge clk);
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;

    // RAM write, then read back; a write whose inputs change after latching.
    wr0 = wr_cnt;
    issue(0, MWRITE, 9'h005, 16'hBEEF, 2, 0);
    check("wr_pulses", wr_cnt - wr0, 1);
    check("wr_addr", last_wr_addr, 8'h05);
    check("wr_data", last_wr_data, 16'hBEEF);
    issue(0, MREAD, 9'h005, 16'h0000, 3, 0);
    check("b_rdata_untouched", b_rdata, 0);
    issue(0, MWRITE, 9'h010, 16'h1234, 2, 1);
    issue(0, MREAD, 9'h010, 16'h0000, 3, 0);

    // Tie after reset: A first, then strict alternation.
    do_reset();
    ack_log.delete();
    fork
      begin
        issue(0, MREAD, 9'h005, 16'h0000, 3, 0);
        issue(0, MREAD, 9'h010, 16'h0000, 0, 0);
        issue(0, MREAD, 9'h005, 16'h0000, 0, 0);
      end
      begin
        issue(1, MREAD, 9'h010, 16'h0000, 0, 0);
        issue(1, MREAD, 9'h005, 16'h0000, 0, 0);
        issue(1, MREAD, 9'h010, 16'h0000, 0, 0);
      end
    join
    check("grant_count", ack_log.size(), 6);
    for (int i = 0; i < ack_log.size(); i++) check($sformatf("grant_order_%0d", i), ack_log[i], i % 2);

    // LED register and an unmapped I/O write.
    wr0 = wr_cnt;
    issue(1, MWRITE, 9'h100, 16'h00A5, 2, 0);
    issue(1, MWRITE, 9'h180, 16'h5A5A, 2, 0);
    check("io_no_ram_write", wr_cnt - wr0, 0);
    check("led_after_io", led, 8'hA5);

    // Switch reads with sign extension; unmapped read returns zero.
    sw = 8'h80;
    issue(0, MREAD, 9'h140, 16'h0000, 2, 0);
    issue(0, MREAD, 9'h1C0, 16'h0000, 2, 0);
    sw = 8'h35;
    issue(0, MREAD, 9'h140, 16'h0000, 2, 0);
    issue(1, MREAD, 9'h140, 16'h0000, 2, 0);

    // Reset during RD_WAIT of an A read kills it.
    issue(0, MREAD, 9'h005, 16'h0000, 3, 0);
    drive(0, MREAD, 9'h010, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    check("busy_in_rd_wait", busy, 1);
    reset = 1'b0;
    drive(0, MNONE, 9'h000, 16'h0000);
    exp_hold[0] = 16'h0000;
    exp_hold[1] = 16'h0000;
    exp_led     = 8'h00;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_a_ack", a_ack, 0);
    check("abort_led", led, 0);
    check("abort_a_rdata", a_rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    issue(0, MREAD, 9'h005, 16'h0000, 3, 0);

    // Randomized concurrent traffic: each port owns half the RAM, only B writes the LEDs.
    random_phase = 1;
    sw = 8'($urandom);
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (4) @(negedge clk);
    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
